// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

    // Control FSM states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    // ALU operation encodings
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_NOP = 4'd5;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // States that hold mem_req and wait on mem_ready
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    // I-type ALU controls: {extop, aluop}
    function automatic logic [4:0] itype_ctrl(input logic [5:0] op);
        case (op)
            OP_ADDI: return {1'b1, ALU_ADD};
            OP_SLTI: return {1'b1, ALU_SLT};
            OP_ANDI: return {1'b0, ALU_AND};
            OP_ORI:  return {1'b0, ALU_OR};
            default: return {1'b1, ALU_NOP};
        endcase
    endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts mem_ready-low cycles of one memory access and flags a timeout.
module mips_mem_wait_timer
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam bit             ENABLED = (MEM_TIMEOUT > 0);
    localparam logic [TO_W-1:0] LIMIT  = TO_W'(MEM_TIMEOUT);

    logic [TO_W-1:0] wait_cnt;

    // Limit reached while the memory is still not ready; a ready in the
    // same cycle wins over the timeout.
    always_comb begin
        timeout = ENABLED && active && !mem_ready && (wait_cnt == LIMIT);
    end

    // Clear on entry to a request state, count stalled cycles, saturate at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (start) begin
            wait_cnt <= '0;
        end else if (active && !mem_ready && (wait_cnt != LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute, memory
// and writeback over a shared ALU and unified memory.
//
// Memory handshake: mem_req is held high for the whole access; the access
// completes in the cycle mem_ready is sampled high while mem_req is high.
// mem_ready is ignored whenever mem_req is low. If the wait limit expires,
// mem_req is dropped in that cycle together with a bus_err pulse.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             irwrite,
    output logic             pcwrite,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             extop,
    output logic [3:0]       aluop,
    output logic             regdst,
    output logic             mem2reg,
    output logic             regwrite,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state;
    state_t     state_next;
    logic       mem_phase;
    logic       timeout;
    logic       wait_start;
    logic       retire;
    logic [4:0] ictrl;

    // Memory wait timer; restarted whenever a request state is (re)entered
    always_comb begin
        mem_phase  = is_mem_state(state);
        wait_start = is_mem_state(state_next) && (!mem_phase || mem_ready || timeout);
        ictrl      = itype_ctrl(opcode);
    end

    mips_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TO_W       (TO_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (wait_start),
        .active   (mem_phase),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + 1'b1;
        end
    end

    // Next state and control decode; everything is held at reset values
    // while rst_n is low so mem_req drops without waiting for a clock.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        pcsrc      = PCSRC_ALU;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        extop      = 1'b1;
        aluop      = ALU_NOP;
        regdst     = 1'b0;
        mem2reg    = 1'b0;
        regwrite   = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        retire     = 1'b0;

        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req = !timeout;
                    alusrcb = SRCB_FOUR;
                    aluop   = ALU_ADD;
                    if (mem_ready) begin
                        irwrite    = 1'b1;
                        pcwrite    = 1'b1;
                        state_next = S_DECODE;
                    end else if (timeout) begin
                        bus_err    = 1'b1;
                        state_next = S_FETCH;
                    end
                end

                S_DECODE: begin
                    // Branch target computed speculatively into ALUOut
                    alusrcb = SRCB_IMM_SH;
                    aluop   = ALU_ADD;
                    case (opcode)
                        OP_RTYPE:                          state_next = S_EXEC_R;
                        OP_LW, OP_SW:                      state_next = S_MEM_ADDR;
                        OP_BEQ:                            state_next = S_BRANCH;
                        OP_J:                              state_next = S_JUMP;
                        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_next = S_EXEC_I;
                        default: begin
                            illegal    = 1'b1;
                            state_next = S_FETCH;
                        end
                    endcase
                end

                S_EXEC_R: begin
                    alusrca    = 1'b1;
                    state_next = S_WB_R;
                    case (func)
                        FN_ADD: aluop = ALU_ADD;
                        FN_SUB: aluop = ALU_SUB;
                        FN_AND: aluop = ALU_AND;
                        FN_OR:  aluop = ALU_OR;
                        FN_SLT: aluop = ALU_SLT;
                        default: begin
                            illegal    = 1'b1;
                            state_next = S_FETCH;
                        end
                    endcase
                end

                S_WB_R: begin
                    regdst     = 1'b1;
                    mem2reg    = 1'b1;
                    regwrite   = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end

                S_EXEC_I: begin
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_IMM;
                    extop      = ictrl[4];
                    aluop      = ictrl[3:0];
                    state_next = S_WB_I;
                end

                S_WB_I: begin
                    // ALU controls held so the result stays stable during the write
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_IMM;
                    extop      = ictrl[4];
                    aluop      = ictrl[3:0];
                    mem2reg    = 1'b1;
                    regwrite   = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end

                S_MEM_ADDR: begin
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_IMM;
                    extop      = 1'b1;
                    aluop      = ALU_ADD;
                    state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end

                S_MEM_RD: begin
                    mem_req = !timeout;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_next = S_WB_MEM;
                    end else if (timeout) begin
                        bus_err    = 1'b1;
                        state_next = S_FETCH;
                    end
                end

                S_MEM_WR: begin
                    mem_req = !timeout;
                    mem_we  = !timeout;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else if (timeout) begin
                        bus_err    = 1'b1;
                        state_next = S_FETCH;
                    end
                end

                S_WB_MEM: begin
                    regwrite   = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end

                S_BRANCH: begin
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_RT;
                    aluop      = ALU_SUB;
                    pcsrc      = PCSRC_ALUOUT;
                    pcwrite    = zero;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end

                S_JUMP: begin
                    pcsrc      = PCSRC_JUMP;
                    pcwrite    = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end

                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed cases plus random instruction
// streams against a per-instruction outcome model.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 8;
    localparam int T     = 4;

    localparam int K_R     = 0;
    localparam int K_I     = 1;
    localparam int K_LW    = 2;
    localparam int K_SW    = 3;
    localparam int K_BEQ   = 4;
    localparam int K_J     = 5;
    localparam int K_BADOP = 6;

    // {mem_req, mem_we, iord, irwrite, pcwrite, pcsrc, alusrca, alusrcb,
    //  extop, aluop, regdst, mem2reg, regwrite, illegal, bus_err}
    localparam logic [19:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0,
                                         1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             irwrite;
    logic             pcwrite;
    logic [1:0]       pcsrc;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic             extop;
    logic [3:0]       aluop;
    logic             regdst;
    logic             mem2reg;
    logic             regwrite;
    logic             illegal;
    logic             bus_err;
    logic [CNT_W-1:0] instr_count;
    logic [19:0]      out_vec;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         len;
        int         irw;
        int         pcw;
        int         rw;
        int         ill;
        int         berr;
        int         req;
        int         we;
        int         iord_n;
        logic [1:0] pcsrc;
        logic       regdst;
        logic       mem2reg;
        logic [3:0] aluop;
        logic       extop;
        bit         has_ex;
        bit         retire;
    } exp_t;

    // observations for the instruction in flight
    int         n_irw, n_pcw, n_rw, n_ill, n_berr, n_req, n_we, n_iord;
    logic [1:0] last_pcsrc;
    logic       last_regdst, last_mem2reg;
    logic [3:0] ex_aluop;
    logic       ex_extop;
    bit         ex_seen;

    // memory model
    int fw, mw, acc_cycles;

    logic [CNT_W-1:0] exp_count;
    logic [5:0] legal_fn [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    logic [5:0] itype_op [4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
    logic [5:0] bad_op   [6] = '{6'h3F, 6'h01, 6'h05, 6'h20, 6'h2A, 6'h10};

    assign out_vec = {mem_req, mem_we, iord, irwrite, pcwrite, pcsrc, alusrca, alusrcb,
                      extop, aluop, regdst, mem2reg, regwrite, illegal, bus_err};

    mips_multicycle_ctrl #(
        .CNT_W      (CNT_W),
        .MEM_TIMEOUT(T),
        .TO_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .func       (func),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .pcsrc      (pcsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .extop      (extop),
        .aluop      (aluop),
        .regdst     (regdst),
        .mem2reg    (mem2reg),
        .regwrite   (regwrite),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .instr_count(instr_count)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ALU op for an R-type func, -1 when undecodable
    function automatic int r_alu(input logic [5:0] fn);
        case (fn)
            6'd32:   return 2;
            6'd34:   return 3;
            6'd36:   return 0;
            6'd37:   return 1;
            6'd42:   return 4;
            default: return -1;
        endcase
    endfunction

    // Outcome of one instruction from its class, operands and memory waits
    function automatic exp_t predict(input int kind, input logic [5:0] fn, input logic z,
                                     input int f_w, input int m_w);
        exp_t e;
        int   a;
        int   acc_len;
        bit   to;
        e = '{default: 0};
        e.aluop = 4'd5;
        e.extop = 1'b1;
        if (f_w > T) begin
            e.len  = T + 1;
            e.req  = T;
            e.berr = 1;
            return e;
        end
        e.len = f_w + 2;
        e.req = f_w + 1;
        e.irw = 1;
        e.pcw = 1;
        case (kind)
            K_R: begin
                a = r_alu(fn);
                e.has_ex = 1'b1;
                if (a < 0) begin
                    e.len += 1;
                    e.ill = 1;
                end else begin
                    e.len += 2;
                    e.rw = 1; e.regdst = 1'b1; e.mem2reg = 1'b1;
                    e.aluop = 4'(a);
                    e.retire = 1'b1;
                end
            end
            K_I: begin
                e.len += 2;
                e.has_ex = 1'b1;
                case (opcode)
                    6'h08:   begin e.aluop = 4'd2; e.extop = 1'b1; end
                    6'h0A:   begin e.aluop = 4'd4; e.extop = 1'b1; end
                    6'h0C:   begin e.aluop = 4'd0; e.extop = 1'b0; end
                    default: begin e.aluop = 4'd1; e.extop = 1'b0; end
                endcase
                e.rw = 1; e.regdst = 1'b0; e.mem2reg = 1'b1;
                e.retire = 1'b1;
            end
            K_LW, K_SW: begin
                e.has_ex = 1'b1;
                e.aluop  = 4'd2;
                to       = (m_w > T);
                acc_len  = to ? T + 1 : m_w + 1;
                e.len   += 1 + acc_len;
                e.iord_n = acc_len;
                e.req   += to ? T : acc_len;
                if (kind == K_SW) e.we = to ? T : acc_len;
                if (to) begin
                    e.berr = 1;
                end else begin
                    e.retire = 1'b1;
                    if (kind == K_LW) begin
                        e.len += 1;
                        e.rw = 1; e.regdst = 1'b0; e.mem2reg = 1'b0;
                    end
                end
            end
            K_BEQ: begin
                e.len += 1;
                e.has_ex = 1'b1;
                e.aluop  = 4'd3;
                if (z) begin
                    e.pcw  += 1;
                    e.pcsrc = 2'd1;
                end
                e.retire = 1'b1;
            end
            K_J: begin
                e.len  += 1;
                e.pcw  += 1;
                e.pcsrc = 2'd2;
                e.retire = 1'b1;
            end
            default: begin
                e.ill = 1;
            end
        endcase
        return e;
    endfunction

    task automatic clear_obs();
        n_irw = 0; n_pcw = 0; n_rw = 0; n_ill = 0; n_berr = 0;
        n_req = 0; n_we = 0; n_iord = 0;
        last_pcsrc = 2'd0; last_regdst = 1'b0; last_mem2reg = 1'b0;
        ex_aluop = 4'd5; ex_extop = 1'b1; ex_seen = 1'b0;
    endtask

    // One clock cycle: answer the memory, sample outputs, advance to the next negedge
    task automatic run_cycle();
        logic acc;
        mem_ready = 1'b0;
        #1;
        acc = mem_req || bus_err;
        if (acc) mem_ready = (acc_cycles >= (iord ? mw : fw));
        else     mem_ready = 1'($urandom_range(0, 1));
        #1;
        if (irwrite) n_irw++;
        if (pcwrite) begin n_pcw++; last_pcsrc = pcsrc; end
        if (regwrite) begin n_rw++; last_regdst = regdst; last_mem2reg = mem2reg; end
        if (illegal) n_ill++;
        if (bus_err) n_berr++;
        if (mem_req) n_req++;
        if (mem_we) n_we++;
        if (iord) n_iord++;
        if (alusrca && !ex_seen) begin
            ex_seen  = 1'b1;
            ex_aluop = aluop;
            ex_extop = extop;
        end
        if (acc && (mem_ready || bus_err)) acc_cycles = 0;
        else if (acc)                      acc_cycles++;
        else                               acc_cycles = 0;
        @(negedge clk);
    endtask

    task automatic do_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int f_w, input int m_w);
        exp_t e;
        opcode = op;
        func   = fn;
        zero   = z;
        fw     = f_w;
        mw     = m_w;
        e = predict(kind, fn, z, f_w, m_w);
        clear_obs();
        repeat (e.len) run_cycle();
        check("next_fetch", 32'({mem_req, iord, alusrcb}), 32'({1'b1, 1'b0, 2'd1}));
        check("irwrite_n", n_irw, e.irw);
        check("pcwrite_n", n_pcw, e.pcw);
        if (e.pcw > 0) check("pcsrc", 32'(last_pcsrc), 32'(e.pcsrc));
        check("regwrite_n", n_rw, e.rw);
        if (e.rw > 0) check("wb_sel", 32'({last_regdst, last_mem2reg}), 32'({e.regdst, e.mem2reg}));
        check("illegal_n", n_ill, e.ill);
        check("bus_err_n", n_berr, e.berr);
        check("mem_req_n", n_req, e.req);
        check("mem_we_n", n_we, e.we);
        check("iord_n", n_iord, e.iord_n);
        check("exec_seen", 32'(ex_seen), 32'(e.has_ex && (f_w <= T)));
        if (ex_seen && e.has_ex) check("exec_alu", 32'({ex_extop, ex_aluop}), 32'({e.extop, e.aluop}));
        if (e.retire) exp_count = exp_count + 1'b1;
        check("instr_count", 32'(instr_count), 32'(exp_count));
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return r % 3;
        case (r)
            6:       return 3;
            7:       return T;
            8:       return T + 1;
            default: return T + 3;
        endcase
    endfunction

    // watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int         kind;
        logic [5:0] op;
        logic [5:0] fn;

        // reset
        rst_n = 1'b0; opcode = 6'h00; func = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        fw = 0; mw = 0; acc_cycles = 0; exp_count = '0;
        #1;
        check("reset_outputs", 32'(out_vec), 32'(RESET_VEC));
        check("reset_count", 32'(instr_count), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_fetch", 32'({mem_req, iord, alusrcb}), 32'({1'b1, 1'b0, 2'd1}));
        @(negedge clk);
        acc_cycles = 0;

        // directed: R add, lw with 3 waits, beq taken / not taken, illegal cases, sw timeout
        do_instr(K_R, 6'h00, 6'd32, 1'b0, 0, 0);
        do_instr(K_LW, 6'h23, 6'd0, 1'b0, 0, 3);
        do_instr(K_BEQ, 6'h04, 6'd0, 1'b1, 0, 0);
        do_instr(K_BEQ, 6'h04, 6'd0, 1'b0, 0, 0);
        do_instr(K_BADOP, 6'h3F, 6'd0, 1'b0, 0, 0);
        do_instr(K_R, 6'h00, 6'h07, 1'b0, 0, 0);
        do_instr(K_SW, 6'h2B, 6'd0, 1'b0, 0, T + 1);
        do_instr(K_SW, 6'h2B, 6'd0, 1'b0, T, T);
        do_instr(K_J, 6'h02, 6'd0, 1'b0, T + 2, 0);
        do_instr(K_I, 6'h0C, 6'd0, 1'b0, 1, 0);

        // random instruction stream, long enough to wrap the counter
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 6);
            fn   = 6'($urandom_range(0, 63));
            case (kind)
                K_R: begin
                    op = 6'h00;
                    if ($urandom_range(0, 3) != 0) fn = legal_fn[$urandom_range(0, 4)];
                end
                K_I:     op = itype_op[$urandom_range(0, 3)];
                K_LW:    op = 6'h23;
                K_SW:    op = 6'h2B;
                K_BEQ:   op = 6'h04;
                K_J:     op = 6'h02;
                default: op = bad_op[$urandom_range(0, 5)];
            endcase
            do_instr(kind, op, fn, 1'($urandom_range(0, 1)), pick_wait(), pick_wait());
        end

        // reset in the middle of a stalled load
        opcode = 6'h23; func = 6'h00; fw = 0; mw = 100;
        clear_obs();
        repeat (3) run_cycle();
        check("rd_before_rst", 32'({mem_req, iord}), 32'({1'b1, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rd_reset_outputs", 32'(out_vec), 32'(RESET_VEC));
        check("mid_rd_reset_count", 32'(instr_count), 32'd0);
        exp_count = '0;
        mem_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rd_release_fetch", 32'({mem_req, iord, alusrcb}), 32'({1'b1, 1'b0, 2'd1}));
        @(negedge clk);
        acc_cycles = 0;
        do_instr(K_R, 6'h00, 6'd42, 1'b0, 0, 0);
        do_instr(K_LW, 6'h23, 6'd0, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
